// File: rtl/pio_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_gen_pkg
//  Description : Register map and parameter encodings for the pio_gen GPIO.
//  Revision    : 1.0  initial release
// ============================================================================
package pio_gen_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage
`default_nettype wire

// File: rtl/pio_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pio_in_sync
//  Description : WIDTH-wide two-flop synchroniser for asynchronous pin inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_in_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta_q;
    logic [WIDTH-1:0] r_sync_q;
    logic [WIDTH-1:0] w_meta_d;
    logic [WIDTH-1:0] w_sync_d;

    always_comb begin
        w_meta_d = i_async;
        w_sync_d = r_meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta_q <= '0;
            r_sync_q <= '0;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
        end
    end

    assign o_sync = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/pio_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pio_gen
//  Description : Avalon-MM GPIO port with direction, edge capture and irq.
//  Revision    : 1.0  initial release
// ============================================================================
module pio_gen
    import pio_gen_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] r_sync_prev_q;
    logic [WIDTH-1:0] r_dout_q;
    logic [WIDTH-1:0] r_dir_q;
    logic [WIDTH-1:0] r_mask_q;
    logic [WIDTH-1:0] r_edge_q;

    logic [WIDTH-1:0] w_sync_prev_d;
    logic [WIDTH-1:0] w_dout_d;
    logic [WIDTH-1:0] w_dir_d;
    logic [WIDTH-1:0] w_mask_d;
    logic [WIDTH-1:0] w_edge_d;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_wd;
    logic             w_wr;
    logic             w_unused_wd;

    pio_in_sync #(
        .WIDTH   (WIDTH)
    ) u_in_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_sync  (w_sync_in)
    );

    assign w_unused_wd = ^writedata;

    always_comb begin
        w_wr          = chipselect & ~write_n;
        w_wd          = writedata[WIDTH-1:0];
        w_sync_prev_d = w_sync_in;

        if (EDGE_TYPE == EDGE_RISE) begin
            w_det = w_sync_in & ~r_sync_prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            w_det = ~w_sync_in & r_sync_prev_q;
        end else begin
            w_det = w_sync_in ^ r_sync_prev_q;
        end

        w_dout_d   = r_dout_q;
        w_dir_d    = r_dir_q;
        w_mask_d   = r_mask_q;
        w_edge_clr = '0;
        if (w_wr) begin
            case (address)
                ADDR_DATA: w_dout_d   = w_wd;
                ADDR_DIR:  w_dir_d    = w_wd;
                ADDR_MASK: w_mask_d   = w_wd;
                ADDR_EDGE: w_edge_clr = w_wd;
                ADDR_SET:  w_dout_d   = r_dout_q | w_wd;
                ADDR_CLR:  w_dout_d   = r_dout_q & ~w_wd;
                default:   ;
            endcase
        end
        // A fresh edge overrides a same-cycle clear so no event is lost.
        w_edge_d = (r_edge_q & ~w_edge_clr) | w_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_prev_q <= '0;
            r_dout_q      <= RESET_VALUE[WIDTH-1:0];
            r_dir_q       <= '0;
            r_mask_q      <= '0;
            r_edge_q      <= '0;
        end else begin
            r_sync_prev_q <= w_sync_prev_d;
            r_dout_q      <= w_dout_d;
            r_dir_q       <= w_dir_d;
            r_mask_q      <= w_mask_d;
            r_edge_q      <= w_edge_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = (r_dout_q & r_dir_q) | (w_sync_in & ~r_dir_q);
            ADDR_DIR:  readdata[WIDTH-1:0] = r_dir_q;
            ADDR_MASK: readdata[WIDTH-1:0] = r_mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = r_edge_q;
            default:   readdata = '0;
        endcase

        if (IRQ_TYPE == IRQ_EDGE) begin
            irq = |(r_edge_q & r_mask_q);
        end else begin
            irq = |(w_sync_in & r_mask_q & ~r_dir_q);
        end
    end

    assign out_port = r_dout_q;
    assign oe_port  = r_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pio_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_gen
//  Description : Self-checking bench for pio_gen (edge-irq and level-irq builds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pio_gen;

    localparam logic [7:0] c_RST = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_e, rd_l;
    logic [7:0]  out_e, out_l, oe_e, oe_l;
    logic        irq_e, irq_l;

    int errors = 0;
    int checks = 0;

    // Behavioural model state; pin_hist[n] is the pin value sampled n+1 edges ago.
    logic [7:0] m_dout, m_dir, m_mask, m_edge;
    logic [7:0] pin_hist [3];

    always #10 clk = ~clk;

    pio_gen #(.WIDTH(8), .RESET_VALUE({24'h0, c_RST}), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_dut_e (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e), .in_port(in_port),
        .out_port(out_e), .oe_port(oe_e), .irq(irq_e)
    );

    pio_gen #(.WIDTH(8), .RESET_VALUE({24'h0, c_RST}), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_dut_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l), .in_port(in_port),
        .out_port(out_l), .oe_port(oe_l), .irq(irq_l)
    );

    task automatic m_reset();
        m_dout = c_RST;
        m_dir  = '0;
        m_mask = '0;
        m_edge = '0;
        for (int i = 0; i < 3; i++) pin_hist[i] = '0;
    endtask

    function automatic logic [7:0] sync_in();
        return pin_hist[1];
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        logic [7:0] v;
        case (a)
            3'd0:    v = (m_dout & m_dir) | (sync_in() & ~m_dir);
            3'd1:    v = m_dir;
            3'd2:    v = m_mask;
            3'd3:    v = m_edge;
            default: v = '0;
        endcase
        return {24'h0, v};
    endfunction

    // One clock: model advances using the inputs held across the edge.
    task automatic step();
        logic [7:0] wd, rise, n_dout, n_dir, n_mask, n_edge;
        wd     = writedata[7:0];
        rise   = pin_hist[1] & ~pin_hist[2];
        n_dout = m_dout; n_dir = m_dir; n_mask = m_mask; n_edge = m_edge;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: n_dout = wd;
                3'd1: n_dir  = wd;
                3'd2: n_mask = wd;
                3'd3: n_edge = m_edge & ~wd;
                3'd4: n_dout = m_dout | wd;
                3'd5: n_dout = m_dout & ~wd;
                default: ;
            endcase
        end
        n_edge = n_edge | rise;
        @(posedge clk);
        if (!reset_n) begin
            m_reset();
        end else begin
            m_dout = n_dout; m_dir = n_dir; m_mask = n_mask; m_edge = n_edge;
            pin_hist[2] = pin_hist[1];
            pin_hist[1] = pin_hist[0];
            pin_hist[0] = in_port;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_e"}, {24'h0, out_e}, {24'h0, m_dout});
        chk({tag, ":out_l"}, {24'h0, out_l}, {24'h0, m_dout});
        chk({tag, ":oe_e"},  {24'h0, oe_e},  {24'h0, m_dir});
        chk({tag, ":oe_l"},  {24'h0, oe_l},  {24'h0, m_dir});
        chk({tag, ":irq_e"}, {31'h0, irq_e}, {31'h0, |(m_edge & m_mask)});
        chk({tag, ":irq_l"}, {31'h0, irq_l}, {31'h0, |(sync_in() & m_mask & ~m_dir)});
        write_n    = 1'b1;
        chipselect = 1'b1;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            chk($sformatf("%s:rd_e%0d", tag, a), rd_e, exp_read(3'(a)));
            chk($sformatf("%s:rd_l%0d", tag, a), rd_l, exp_read(3'(a)));
        end
        chipselect = 1'b0;
        address    = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        m_reset();
        step(); step();
        check_all("reset");
        reset_n = 1'b1;
        step();
        check_all("post_reset");

        wr(3'd0, 32'h0F); chk("data_wr", {24'h0, out_e}, 32'h0F);
        wr(3'd4, 32'h30); chk("set_wr",  {24'h0, out_e}, 32'h3F);
        wr(3'd5, 32'h05); chk("clr_wr",  {24'h0, out_e}, 32'h3A);
        wr(3'd1, 32'hFF); check_all("dir_ff");
        wr(3'd2, 32'hFFFF_FFFF); check_all("mask_wide");

        // Rising edge on bit 0 with edge-mode irq.
        wr(3'd1, 32'h00); wr(3'd2, 32'h01);
        step(); step(); step();
        check_all("quiet");
        in_port = 8'h01;
        step(); check_all("rise_k");
        step(); check_all("rise_k1");
        step(); check_all("rise_k2");
        chk("edge_set", {31'h0, irq_e}, 32'h1);
        wr(3'd3, 32'h01); check_all("w1c");
        chk("edge_clr", {31'h0, irq_e}, 32'h0);
        in_port = 8'h00;
        step(); step(); step(); check_all("fall");

        // Re-arm, then clear exactly as a second rise is detected.
        in_port = 8'h01;
        step(); step(); step(); check_all("rearm");
        in_port = 8'h00; step(); step(); step();
        in_port = 8'h01; step(); step();
        wr(3'd3, 32'h01); check_all("w1c_vs_set");
        chk("set_wins", {31'h0, irq_e}, 32'h1);

        // Level-mode irq on bit 1.
        wr(3'd2, 32'h02);
        in_port = 8'h02;
        step(); check_all("lvl_k");
        step(); check_all("lvl_k1");
        chk("lvl_irq", {31'h0, irq_l}, 32'h1);
        wr(3'd1, 32'h02); check_all("lvl_dir");
        chk("lvl_dir_irq", {31'h0, irq_l}, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            in_port = 8'($urandom);
            if ($urandom_range(0, 9) < 4) begin
                address = 3'($urandom_range(0, 7)); writedata = $urandom;
                chipselect = 1'b1; write_n = 1'b0;
            end
            step();
            chipselect = 1'b0; write_n = 1'b1;
            check_all($sformatf("rnd%0d", n));
        end

        // Async reset with pending edges.
        wr(3'd1, 32'h00); wr(3'd2, 32'hFF);
        in_port = 8'h00; step(); step(); step();
        in_port = 8'hFF; step(); step(); step();
        check_all("pre_areset");
        chk("pending", {31'h0, irq_e}, 32'h1);
        #3 reset_n = 1'b0;
        m_reset();
        #1;
        check_all("areset");
        #1 reset_n = 1'b1;
        step();
        check_all("after_areset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_gen.md
# pio_gen

Parametrised Avalon-MM general-purpose I/O port for the Nios CPU subsystem. It extends the fixed 2-bit output PIO to a configurable width with per-bit direction control, synchronised inputs, edge capture and a maskable interrupt. It sits on the CPU data master as an Avalon slave with zero-wait, zero-latency reads and drives board pins through `out_port`/`oe_port`.

## Interface
- `WIDTH`, 8: port width, 1..32.
- `RESET_VALUE`, 0: reset value of the output data register (low `WIDTH` bits used).
- `EDGE_TYPE`, 0: captured edge; 0 rising, 1 falling, 2 any.
- `IRQ_TYPE`, 1: 0 level (irq from pin state), 1 edge (irq from edge capture).
- `clk`  in  1  single system clock; everything is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address within the register map.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data; bits above `WIDTH` are ignored.
- `readdata`  out  32  combinational read data; bits above `WIDTH` are 0.
- `in_port`  in  WIDTH  asynchronous pin inputs.
- `out_port`  out  WIDTH  output data register.
- `oe_port`  out  WIDTH  per-bit output enable; 1 means output, equal to the direction register.
- `irq`  out  1  interrupt request, active high.

## Operation
- Register map. Reads are side-effect free.
  - 0 DATA: write loads data_out. Read returns per bit: data_out where dir=1, else sync_in.
  - 1 DIR: read/write direction.
  - 2 MASK: read/write irq mask.
  - 3 EDGE: read edge capture; write-1-to-clear.
  - 4 SET: `data_out |= wd`; reads 0.
  - 5 CLR: `data_out &= ~wd`; reads 0.
  - 6, 7: reads 0; writes ignored.
- Reset values: data_out = RESET_VALUE, DIR 0 (all inputs), MASK 0, EDGE 0, sync flops 0, `irq` 0. Therefore `out_port` = RESET_VALUE and `oe_port` = 0.
- Input path: `in_port` passes through a 2-flop synchroniser to sync_in, then 1 more flop to sync_prev.
- Edge detection, per bit:
  - rise = sync_in & ~sync_prev
  - fall = ~sync_in & sync_prev
  - The edge selected by EDGE_TYPE sets the EDGE bit.
  - Detection runs regardless of DIR.
- Simultaneous W1C and new edge on the same bit: the set wins, and the bit stays 1.
- `irq`, combinational from registers:
  - IRQ_TYPE=1: `|(EDGE & MASK)`.
  - IRQ_TYPE=0: `|(sync_in & MASK & ~DIR)`.
- Asynchronous reset mid-operation clears all state immediately. Pending edges are lost and `irq` drops in the same cycle.

## Timing
- Write: register updates on the clock edge where the write strobe is sampled, and is visible on `out_port`/`oe_port`/`readdata` right after that edge.
- Read: zero latency; `readdata` is valid in the cycle `address` is valid.
- Pin change set up before edge k:
  - sync_in updates at edge k+1, so DATA read reflects it after k+1.
  - EDGE bit sets at edge k+2.
  - `irq` (edge mode) asserts after k+2.
  - `irq` (level mode) asserts after k+1.
- W1C of the last pending masked bit at edge j: `irq` deasserts after j.
- Pulses shorter than one clock may be missed. This is accepted behaviour.

## Structure
- Package `pio_gen_pkg`:
  - address constants: ADDR_DATA, ADDR_DIR, ADDR_MASK, ADDR_EDGE, ADDR_SET, ADDR_CLR
  - EDGE_TYPE and IRQ_TYPE encodings as localparams.
- Sub-module `pio_in_sync`: `WIDTH`-wide 2-flop synchroniser with async active-low reset, reused by future input peripherals.
- Everything else, including the register file, edge logic and read mux, lives in the top level.

## Test plan
- Reset with RESET_VALUE=8'hA5: `out_port`=A5, `oe_port`=00, `irq`=0, all register reads return reset values; addresses 6/7 read 0.
- Write DATA=0F, SET=30, CLR=05: `out_port` goes 0F, then 3F, then 3A; DIR=FF makes DATA read 3A.
- WIDTH=8, write 32'hFFFF_FFFF to MASK: MASK reads 0000_00FF.
- EDGE_TYPE=0, IRQ_TYPE=1, MASK=01, `in_port[0]` rises before edge k: EDGE reads 01 after k+2 and `irq`=1. Write EDGE=01: EDGE=00 and `irq`=0. A falling edge sets nothing.
- Second rising edge on bit 0 detected in the same cycle as a W1C write of 01: EDGE remains 01 and `irq` stays 1.
- IRQ_TYPE=0, MASK=02, `in_port[1]` held high: `irq`=1 from k+1. Setting DIR[1]=1 drops `irq`. Asserting `reset_n` low mid-operation zeroes `irq` and EDGE asynchronously.
